// File: rtl/auth_pkg.sv
// Shared types and command constants for the rider-authorization block.
// Imported by the UART receiver, the auth top and the bench.
package auth_pkg;

  typedef enum logic [1:0] {
    OFF,
    PWR1,
    PWR2
  } auth_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic [7:0] GO_CMD   = 8'h67;
  localparam logic [7:0] STOP_CMD = 8'h73;

endpackage

// File: rtl/auth_blk_uart_rx.sv
// 8N1 UART receiver: RX synchronizer, mid-bit sampling FSM,
// one-clk rx_rdy / frm_err pulses.
module uart_rx
  import auth_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);

  localparam logic [11:0] BAUD_FULL = 12'(BAUD_DIV);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2);

  rx_state_t   state, nxt;
  logic        rx_ff1, rx_s, rx_q;
  logic [11:0] baud_cnt, baud_nxt;
  logic [3:0]  bit_cnt, bit_nxt;
  logic [7:0]  shift_reg, shift_nxt;
  logic [7:0]  data_nxt;
  logic        rdy_nxt, ferr_nxt;
  logic        fall, expire;

  assign fall   = rx_q & ~rx_s;
  assign expire = (baud_cnt == 12'd0);

  always_comb begin
    nxt       = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    data_nxt  = rx_data;
    rdy_nxt   = 1'b0;
    ferr_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          baud_nxt = BAUD_HALF;
          nxt      = START;
        end
      end
      START: begin
        if (!expire) begin
          baud_nxt = baud_cnt - 12'd1;
        end else if (!rx_s) begin
          baud_nxt = BAUD_FULL;
          bit_nxt  = 4'd0;
          nxt      = DATA;
        end else begin
          nxt = IDLE;
        end
      end
      DATA: begin
        if (!expire) begin
          baud_nxt = baud_cnt - 12'd1;
        end else begin
          shift_nxt = {rx_s, shift_reg[7:1]};
          bit_nxt   = bit_cnt + 4'd1;
          baud_nxt  = BAUD_FULL;
          if (bit_cnt == 4'd7) nxt = STOP;
        end
      end
      STOP: begin
        if (!expire) begin
          baud_nxt = baud_cnt - 12'd1;
        end else begin
          if (rx_s) begin
            data_nxt = shift_reg;
            rdy_nxt  = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // rx_q trails rx_s by one clk so IDLE can see the falling edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ff1    <= 1'b1;
      rx_s      <= 1'b1;
      rx_q      <= 1'b1;
      state     <= IDLE;
      baud_cnt  <= 12'd0;
      bit_cnt   <= 4'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_rdy    <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      rx_ff1    <= RX;
      rx_s      <= rx_ff1;
      rx_q      <= rx_s;
      state     <= nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      rx_data   <= data_nxt;
      rx_rdy    <= rdy_nxt;
      frm_err   <= ferr_nxt;
    end
  end

endmodule

// File: rtl/auth_blk.sv
// Rider-authorization front end: UART command bytes plus rider_off
// drive the power-up state machine and the registered pwr_up gate.
module auth_blk
  import auth_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  output logic       frm_err
);

  auth_state_t state, nxt;
  logic        go, stop;

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .rx_data(rx_data),
    .rx_rdy (rx_rdy),
    .frm_err(frm_err)
  );

  assign go   = rx_rdy && (rx_data == GO_CMD);
  assign stop = rx_rdy && (rx_data == STOP_CMD);

  // stepping off in PWR2 wins over any byte arriving the same clk
  always_comb begin
    nxt = state;
    unique case (state)
      OFF: begin
        if (go) nxt = PWR1;
      end
      PWR1: begin
        if (stop) nxt = rider_off ? OFF : PWR2;
      end
      PWR2: begin
        if (rider_off) nxt = OFF;
        else if (go)   nxt = PWR1;
      end
      default: nxt = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= OFF;
      pwr_up <= 1'b0;
    end else begin
      state  <= nxt;
      pwr_up <= (nxt != OFF);
    end
  end

endmodule

// File: doc/auth_blk.md
Name: auth_blk

Overview:
Rider-authorization front end of the Segway. It receives serial command bytes from the Bluetooth/UART link and runs the power-up authorization state machine. It drives pwr_up, which gates the balance controller and motor drive downstream. Power-up needs a 'g' byte. Power-down needs an 's' byte plus the rider stepping off, in either order.

Parameters:
BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud).
GO_CMD, 8'h67, ASCII 'g' authorization byte.
STOP_CMD, 8'h73, ASCII 's' stop byte.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
RX  in  1  asynchronous UART serial input, idle high
rider_off  in  1  high when load-cell sum is below rider threshold (synchronous to clk)
pwr_up  out  1  registered; high while authorized
rx_rdy  out  1  one-clk pulse: byte valid on rx_data
rx_data  out  8  last received byte, held until next rx_rdy
frm_err  out  1  one-clk pulse: stop bit sampled low

Behaviour:
- Reset (rst_n low at posedge clk): pwr_up=0, rx_rdy=0, frm_err=0, rx_data=8'h00.
  - RX synchronizer flops go to 1.
  - UART FSM goes to IDLE; auth FSM goes to OFF.
  - Counters clear.
  - A reset mid-frame discards the partial byte and produces no rx_rdy.
- RX goes through a 2-flop synchronizer. All UART logic uses the synchronized value only.
- UART FSM states and transitions:
  - IDLE: on synchronized RX 1->0 edge, load baud_cnt=BAUD_DIV/2 and go to START.
  - START: when baud_cnt hits 0, sample RX.
    - If RX is still 0: load BAUD_DIV, bit_cnt=0, go to DATA.
    - Otherwise: glitch; return to IDLE with no output.
  - DATA: each baud_cnt expiry shifts the sample into shift_reg (LSB first) and reloads BAUD_DIV. After bit_cnt reaches 8, go to STOP.
  - STOP: at expiry, sample RX.
    - If 1: rx_data<=shift_reg and rx_rdy=1 for exactly one clk.
    - If 0: frm_err=1 for one clk; rx_data and rx_rdy are unchanged.
    - Either way, return to IDLE. A new start edge is accepted the very next cycle.
- baud_cnt is 12 bits, down-counting. bit_cnt is 4 bits.
- Auth FSM states: OFF, PWR1 (authorized, 's' not yet seen), PWR2 ('s' received, waiting for rider_off).
  - OFF -> PWR1: rx_rdy & rx_data==GO_CMD.
  - PWR1 -> OFF: rx_rdy & rx_data==STOP_CMD & rider_off.
  - PWR1 -> PWR2: rx_rdy & rx_data==STOP_CMD & !rider_off.
  - PWR2 -> OFF: rider_off (priority over a simultaneous byte).
  - PWR2 -> PWR1: rx_rdy & rx_data==GO_CMD & !rider_off.
  - rider_off alone in PWR1 does not power down.
  - Any other byte is ignored in every state.
- pwr_up is registered: next_state!=OFF, latched on the same edge as the state.
  - pwr_up changes on the first posedge after the rx_rdy cycle.
  - Benches checking two negedges after the rx_rdy rise therefore see the new value.
- rx_rdy and the auth decision use the same registered byte. There is no extra pipeline stage.

Decomposition:
- auth_pkg holds:
  - typedef enum logic [1:0] auth_state_t {OFF, PWR1, PWR2};
  - typedef enum logic [1:0] rx_state_t {IDLE, START, DATA, STOP};
  - localparams GO_CMD and STOP_CMD, also imported by the bench's sendCmd users.
- Sub-module uart_rx contains the synchronizer, UART FSM, baud/bit counters and shift register. Its ports are clk, rst_n, RX, rx_data, rx_rdy, frm_err, with BAUD_DIV as a parameter.
- auth_blk instantiates uart_rx and contains the auth FSM and the pwr_up flop.

Test Plan:
- Reset then idle RX=1 for 10000 clks -> pwr_up=0, rx_rdy never pulses, rx_data=8'h00.
- Send 8'h67 via UART tx (BAUD_DIV=2604) -> rx_rdy pulses once with rx_data=8'h67; pwr_up=1 by the 2nd negedge after rx_rdy.
- From PWR1 with rider_off=0, send 8'h73 -> pwr_up stays 1 (PWR2). Raise rider_off -> pwr_up=0 one clk later.
- From PWR1 with rider_off=1, send 8'h73 -> pwr_up=0 by the 2nd negedge after rx_rdy. From PWR2, send 8'h67 with rider_off=0 -> back to PWR1, pwr_up=1.
- From PWR1 send 8'h78 ('x'), then raise rider_off -> pwr_up stays 1 (no power-down without 's').
- Framing and glitch cases:
  - Frame 8'h67 with the stop bit forced to 0 -> frm_err pulse, no rx_rdy, pwr_up stays 0.
  - 500-clk RX low glitch -> no byte.
  - rst_n low mid-frame -> no rx_rdy, and the next full 'g' frame is received correctly.
